sort_ctrl: RTL and testbench

Sequencer that owns an 8-entry x 8-bit synchronous-read scratch memory. It shares that memory between a host port and an in-place ascending selection-sort engine.
- While idle (ready=1), the host reads and writes entries.
- A start pulse hands the memory to the sort engine until it finishes.
- This is the controller layer the sort datapath needs, with fixed, countable cycle latency.

---
 rtl/sort_pkg.sv | 20 ++
 rtl/sort_mem.sv | 27 ++
 rtl/sort_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sort_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and default sizing for the sort controller slice.
package sort_pkg;

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned AW_DEF    = 3;
  localparam int unsigned W_DEF     = 8;

  // Sequencer states: IDLE owns the host port, the rest walk the selection sort.
  typedef enum logic [2:0] {
    IDLE,
    RDI,
    LDI,
    RDJ,
    CMP,
    CHK,
    SW1,
    SW2
  } state_e;

endpackage

// File: rtl/sort_mem.sv
// DEPTH x W scratch memory: one synchronous read port, one write port, no reset.
module sort_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned W     = 8
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  // Write lands at the issuing edge; read data is registered one edge later.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sort_ctrl.sv
// Shares a scratch memory between the host port and an in-place ascending
// selection-sort engine with fixed, countable cycle latency.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned W     = W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  datain,
  output logic [W-1:0]  dataout,
  output logic          ready,
  output logic          done,
  output logic [AW-1:0] swaps
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic [AW-1:0] mi_q, mi_d;
  logic [W-1:0]  ai_q, ai_d;
  logic [W-1:0]  min_q, min_d;
  logic [AW-1:0] swaps_q, swaps_d;
  logic          done_q, done_d;
  logic [W-1:0]  dataout_q, dataout_d;
  logic          rd_pend_q, rd_pend_d;

  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [W-1:0]  mem_rdata;
  logic          mem_wr_req;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [W-1:0]  mem_wr_data;

  sort_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (W)
  ) u_mem (
    .clk     (clk),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rdata),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_data (mem_wr_data)
  );

  // Memory port muxing: host owns the ports in IDLE, the engine otherwise.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_req  = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (!start && wr) begin
          mem_wr_req  = 1'b1;
          mem_wr_addr = addr;
          mem_wr_data = datain;
        end else if (!start) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = addr;
        end
      end
      RDI: begin
        if (i_q != LAST) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = i_q;
        end
      end
      RDJ: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = j_q;
      end
      SW1: begin
        mem_wr_req  = 1'b1;
        mem_wr_addr = mi_q;
        mem_wr_data = ai_q;
      end
      SW2: begin
        mem_wr_req  = 1'b1;
        mem_wr_addr = i_q;
        mem_wr_data = min_q;
      end
      default: ;
    endcase
    // Reset is asynchronous to the memory, so block writes while it is held.
    mem_wr_en = mem_wr_req & ~rst;
  end

  // Next-state, index/min bookkeeping and host read-data capture.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    mi_d      = mi_q;
    ai_d      = ai_q;
    min_d     = min_q;
    swaps_d   = swaps_q;
    done_d    = 1'b0;
    rd_pend_d = 1'b0;
    dataout_d = rd_pend_q ? mem_rdata : dataout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RDI;
          i_d     = '0;
          swaps_d = '0;
        end else if (!wr) begin
          rd_pend_d = 1'b1;
        end
      end
      RDI: begin
        if (i_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          j_d     = i_q + ONE;
          state_d = LDI;
        end
      end
      LDI: begin
        ai_d    = mem_rdata;
        min_d   = mem_rdata;
        mi_d    = i_q;
        state_d = RDJ;
      end
      RDJ: state_d = CMP;
      CMP: begin
        if (mem_rdata < min_q) begin
          min_d = mem_rdata;
          mi_d  = j_q;
        end
        if (j_q == LAST) begin
          state_d = CHK;
        end else begin
          j_d     = j_q + ONE;
          state_d = RDJ;
        end
      end
      CHK: begin
        if (mi_q != i_q) begin
          state_d = SW1;
        end else begin
          i_d     = i_q + ONE;
          state_d = RDI;
        end
      end
      SW1: state_d = SW2;
      SW2: begin
        swaps_d = swaps_q + ONE;
        i_d     = i_q + ONE;
        state_d = RDI;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      mi_q      <= '0;
      ai_q      <= '0;
      min_q     <= '0;
      swaps_q   <= '0;
      done_q    <= 1'b0;
      dataout_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      mi_q      <= mi_d;
      ai_q      <= ai_d;
      min_q     <= min_d;
      swaps_q   <= swaps_d;
      done_q    <= done_d;
      dataout_q <= dataout_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = done_q;
  assign swaps   = swaps_q;
  assign dataout = dataout_q;

endmodule

// File: tb/tb_sort_ctrl.sv
// Directed-vector bench for sort_ctrl with hand-computed expectations.
module tb_sort_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       wr;
  logic [2:0] addr;
  logic [7:0] datain;
  logic [7:0] dataout;
  logic       ready;
  logic       done;
  logic [2:0] swaps;

  int unsigned n_vec;
  int unsigned n_bad;

  logic [7:0] vec   [8];
  logic [7:0] exp_a [8];

  sort_ctrl #(
    .DEPTH (8),
    .AW    (3),
    .W     (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .wr      (wr),
    .addr    (addr),
    .datain  (datain),
    .dataout (dataout),
    .ready   (ready),
    .done    (done),
    .swaps   (swaps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; datain = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, output logic [7:0] d);
    wr = 1'b0; start = 1'b0; addr = a;
    tick();
    tick();
    d = dataout;
  endtask

  task automatic load_vec();
    for (int k = 0; k < 8; k++) host_write(3'(k), vec[k]);
  endtask

  task automatic readback(input string tag);
    logic [7:0] d;
    for (int k = 0; k < 8; k++) begin
      host_read(3'(k), d);
      check_val($sformatf("%s[%0d]", tag, k), {24'd0, d}, {24'd0, exp_a[k]});
    end
  endtask

  // Start a sort and count edges until ready returns; optionally inject
  // host activity mid-sort (inj_n) or a write alongside the start (clash).
  task automatic run_sort(input string tag, input int exp_n, input int exp_sw,
                          input int inj_n, input logic inj_wr, input logic inj_start,
                          input logic clash);
    int   n;
    logic early_done;
    start = 1'b1;
    if (clash) begin
      wr = 1'b1; addr = 3'd0; datain = 8'hEE;
    end
    tick();
    start = 1'b0; wr = 1'b0;
    check_val({tag, "_busy"}, {31'd0, ready}, 32'd0);
    n = 0;
    early_done = 1'b0;
    while (!ready && n < 200) begin
      if (done) early_done = 1'b1;
      if (n == inj_n) begin
        wr = inj_wr; start = inj_start; addr = 3'd7; datain = 8'h55;
      end
      tick();
      wr = 1'b0; start = 1'b0;
      n++;
    end
    check_val({tag, "_latency"}, n, exp_n);
    check_val({tag, "_done_early"}, {31'd0, early_done}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done}, 32'd1);
    check_val({tag, "_swaps"}, {29'd0, swaps}, exp_sw);
    tick();
    check_val({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check_val({tag, "_stay_ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] d;
    n_vec = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; wr = 1'b0; addr = '0; datain = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", {31'd0, ready}, 32'd1);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_swaps", {29'd0, swaps}, 32'd0);
    check_val("rst_dataout", {24'd0, dataout}, 32'd0);
    rst = 1'b0;
    tick();

    // Host access and two-edge read latency.
    host_write(3'd0, 8'h11);
    check_val("host_ready_wr", {31'd0, ready}, 32'd1);
    host_write(3'd3, 8'h5A);
    addr = 3'd0;
    tick();
    tick();
    check_val("host_rd0", {24'd0, dataout}, 32'h11);
    addr = 3'd3;
    tick();
    check_val("host_rd3_early", {24'd0, dataout}, 32'h11);
    tick();
    check_val("host_rd3", {24'd0, dataout}, 32'h5A);
    check_val("host_ready_rd", {31'd0, ready}, 32'd1);

    // Already sorted.
    vec = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    exp_a = vec;
    load_vec();
    run_sort("sorted", 78, 0, -1, 1'b0, 1'b0, 1'b0);
    readback("sorted");

    // Reverse order.
    vec = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    exp_a = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load_vec();
    run_sort("reverse", 86, 4, -1, 1'b0, 1'b0, 1'b0);
    readback("reverse");

    // Duplicates: six selection-sort swaps with leftmost-minimum ties.
    vec = '{8'd3, 8'd1, 8'd3, 8'd1, 8'hFF, 8'd0, 8'd0, 8'hFF};
    exp_a = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd3, 8'hFF, 8'hFF};
    load_vec();
    run_sort("dups", 90, 6, -1, 1'b0, 1'b0, 1'b0);
    readback("dups");

    // All equal: ties never swap.
    vec = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    exp_a = vec;
    load_vec();
    run_sort("equal", 78, 0, -1, 1'b0, 1'b0, 1'b0);
    readback("equal");

    // start and wr together: write to addr 0 dropped.
    vec = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    exp_a = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load_vec();
    run_sort("clash", 86, 4, -1, 1'b0, 1'b0, 1'b1);
    readback("clash");

    // wr while busy ignored.
    load_vec();
    run_sort("busywr", 86, 4, 10, 1'b1, 1'b0, 1'b0);
    readback("busywr");

    // start while busy ignored.
    load_vec();
    run_sort("busystart", 86, 4, 30, 1'b0, 1'b1, 1'b0);
    readback("busystart");

    // Reset mid-sort, then fresh host access.
    load_vec();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check_val("midrst_busy", {31'd0, ready}, 32'd0);
    check_val("midrst_swaps_pre", {29'd0, swaps}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("midrst_ready", {31'd0, ready}, 32'd1);
    check_val("midrst_done", {31'd0, done}, 32'd0);
    check_val("midrst_swaps", {29'd0, swaps}, 32'd0);
    check_val("midrst_dataout", {24'd0, dataout}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    host_write(3'd0, 8'h3C);
    host_read(3'd0, d);
    check_val("postrst_rd0", {24'd0, d}, 32'h3C);
    check_val("postrst_ready", {31'd0, ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
